// File: rtl/clk_div_monitor_if.sv
// rtl/clk_div_monitor_if.sv - bundle of the divided-clock input, fault clear and lock/period status signals
interface clk_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             clk_div;
    logic             clr_fault;
    logic             locked;
    logic             fault;
    logic [CNT_W-1:0] period;
    logic             period_valid;

    modport master (
        output clk_div,
        output clr_fault,
        input  locked,
        input  fault,
        input  period,
        input  period_valid
    );

    modport slave (
        input  clk_div,
        input  clr_fault,
        output locked,
        output fault,
        output period,
        output period_valid
    );
endinterface

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - period/lock monitor for the divided PLL clock, sampled in the reference domain
// Optional high-time (duty) check is built when CLK_DIV_DUTY_CHECK_EN is defined.
module clk_div_monitor #(
    parameter int RATIO      = 4,
    parameter int LOCK_COUNT = 16,
    parameter int TIMEOUT    = 8,
    parameter int CNT_W      = 8
) (
    input  logic              clk_10M_ref,
    input  logic              rst,
    clk_div_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_LOCKED,
        ST_LOST
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TMO   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_RATIO = CNT_W'(RATIO);
    localparam logic [7:0]       GOOD_LOCK = 8'(LOCK_COUNT);

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_good;
    state_t           r_state;
    logic             r_locked;
    logic             r_fault;
    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;

    logic             w_re;
    logic [CNT_W-1:0] w_meas;
    logic             w_timeout;
    logic             w_derr;
    logic             w_good_per;
    state_t           w_state_n;
    logic [7:0]       w_good_n;
    logic             w_fault_set;
    logic             w_report;

    assign w_re       = r_s2 & ~r_s3;
    assign w_meas     = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);
    assign w_timeout  = (r_cnt == CNT_TMO) && !w_re;
    assign w_good_per = w_re && (w_meas == CNT_RATIO) && !w_derr;

    always_ff @(posedge clk_10M_ref or posedge rst) begin
        if (rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_s3  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= bus.clk_div;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_re) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

`ifdef CLK_DIV_DUTY_CHECK_EN
    logic             w_fe;
    logic [CNT_W-1:0] r_hcnt;
    logic             r_derr;

    assign w_fe   = ~r_s2 & r_s3;
    assign w_derr = r_derr;

    // The re cycle itself is a high cycle, so the count restarts at 1 rather than 0.
    always_ff @(posedge clk_10M_ref or posedge rst) begin
        if (rst) begin
            r_hcnt <= '0;
            r_derr <= 1'b0;
        end else begin
            if (w_re) begin
                r_hcnt <= CNT_ONE;
            end else if (r_s2 && (r_hcnt != CNT_MAX)) begin
                r_hcnt <= r_hcnt + CNT_ONE;
            end
            if (w_re) begin
                r_derr <= 1'b0;
            end else if (w_fe && (r_hcnt != CNT_W'(RATIO / 2))) begin
                r_derr <= 1'b1;
            end
        end
    end
`else
    assign w_derr = 1'b0;
`endif

    always_comb begin
        w_state_n   = r_state;
        w_good_n    = r_good;
        w_fault_set = 1'b0;
        w_report    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_re) begin
                    w_state_n = ST_ACQUIRE;
                    w_good_n  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (w_re) begin
                    w_report = 1'b1;
                    if (w_good_per) begin
                        w_good_n = r_good + 8'd1;
                        if (w_good_n == GOOD_LOCK) begin
                            w_state_n = ST_LOCKED;
                        end
                    end else begin
                        w_good_n = '0;
                    end
                end else if (w_timeout) begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (w_re) begin
                    w_report = 1'b1;
                    if (!w_good_per) begin
                        w_state_n   = ST_LOST;
                        w_fault_set = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_n   = ST_LOST;
                    w_fault_set = 1'b1;
                end
            end
            ST_LOST: begin
                if (w_re) begin
                    w_state_n = ST_ACQUIRE;
                    w_good_n  = '0;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_good_n  = '0;
            end
        endcase
    end

    // locked follows the next state so it appears one cycle after the locking re.
    always_ff @(posedge clk_10M_ref or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_good         <= '0;
            r_locked       <= 1'b0;
            r_fault        <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_good         <= w_good_n;
            r_locked       <= (w_state_n == ST_LOCKED);
            r_period_valid <= w_report;
            if (w_report) begin
                r_period <= w_meas;
            end
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end else if (bus.clr_fault) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign bus.locked       = r_locked;
    assign bus.fault        = r_fault;
    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed and randomized bench for clk_div_monitor against an edge-timing reference model
module tb_clk_div_monitor;
    localparam int RATIO      = 4;
    localparam int LOCK_COUNT = 16;
    localparam int TIMEOUT    = 8;
    localparam int CNT_W      = 8;
    localparam int CNT_MAXV   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clk_div_monitor_if #(.CNT_W(CNT_W)) bus ();

    clk_div_monitor #(
        .RATIO      (RATIO),
        .LOCK_COUNT (LOCK_COUNT),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_10M_ref (clk),
        .rst         (rst),
        .bus         (bus)
    );

    always #50 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: driven waveform history indexed by reference edge since reset release.
    bit hist[$];
    int m_n;
    int m_state;
    int m_good;
    int m_last;
    bit m_derr;
    bit e_locked;
    bit e_fault;
    bit e_pv;
    int e_period;
    bit prev_pv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit h(input int i);
        return (i < 0) ? 1'b0 : hist[i];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_n      = 0;
        m_state  = 0;
        m_good   = 0;
        m_last   = -1;
        m_derr   = 1'b0;
        e_locked = 1'b0;
        e_fault  = 1'b0;
        e_pv     = 1'b0;
        e_period = 0;
        prev_pv  = 1'b0;
    endtask

    // A rise driven before edge k is seen as re two edges later; periods are rise-to-rise distances.
    task automatic model_edge(input bit clr);
        bit re;
        bit tmo;
        bit good_p;
        bit fset;
        int per;
        re     = h(m_n - 2) && !h(m_n - 3);
        per    = m_n - m_last;
        if (per > CNT_MAXV) per = CNT_MAXV;
        tmo    = !re && ((m_n - m_last - 1) == TIMEOUT);
        good_p = re && (per == RATIO) && !m_derr;
        fset   = 1'b0;
        e_pv   = 1'b0;
        case (m_state)
            0: if (re) begin m_state = 1; m_good = 0; end
            1: begin
                if (re) begin
                    e_pv = 1'b1;
                    e_period = per;
                    if (good_p) begin
                        m_good++;
                        if (m_good == LOCK_COUNT) m_state = 2;
                    end else begin
                        m_good = 0;
                    end
                end else if (tmo) begin
                    m_state = 0;
                end
            end
            2: begin
                if (re) begin
                    e_pv = 1'b1;
                    e_period = per;
                    if (!good_p) begin m_state = 3; fset = 1'b1; end
                end else if (tmo) begin
                    m_state = 3;
                    fset = 1'b1;
                end
            end
            default: if (re) begin m_state = 1; m_good = 0; end
        endcase
        e_locked = (m_state == 2);
        if (fset) e_fault = 1'b1;
        else if (clr) e_fault = 1'b0;
`ifdef CLK_DIV_DUTY_CHECK_EN
        begin
            bit fe;
            fe = !h(m_n - 2) && h(m_n - 3);
            if (re) m_derr = 1'b0;
            else if (fe && ((m_n - m_last) != RATIO / 2)) m_derr = 1'b1;
        end
`endif
        if (re) m_last = m_n;
    endtask

    task automatic cyc(input bit v, input bit clr);
        @(negedge clk);
        bus.clk_div   = v;
        bus.clr_fault = clr;
        hist.push_back(v);
        @(posedge clk);
        model_edge(clr);
        m_n++;
        #1;
        check("locked", 32'(bus.locked), 32'(e_locked));
        check("fault", 32'(bus.fault), 32'(e_fault));
        check("period_valid", 32'(bus.period_valid), 32'(e_pv));
        check("period", 32'(bus.period), 32'(e_period));
        check("pv_back_to_back", 32'(prev_pv && bus.period_valid), 32'd0);
        prev_pv = bus.period_valid;
    endtask

    task automatic wave(input int hi, input int lo, input int cnt);
        repeat (cnt) begin
            repeat (hi) cyc(1'b1, 1'b0);
            repeat (lo) cyc(1'b0, 1'b0);
        end
    endtask

    function automatic bit rclr();
        return ($urandom_range(0, 19) == 0);
    endfunction

    initial begin
        int hi;
        int lo;
        int sel;
        bus.clk_div   = 1'b0;
        bus.clr_fault = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_period", 32'(bus.period), 32'd0);
        check("rst_period_valid", 32'(bus.period_valid), 32'd0);
        #1 rst = 1'b0;

        // Ideal input: lock exactly on the 17th rise.
        wave(2, 2, 16);
        check("ideal_not_yet_locked", 32'(bus.locked), 32'd0);
        wave(2, 2, 1);
        check("ideal_locked", 32'(bus.locked), 32'd1);
        check("ideal_period", 32'(bus.period), 32'd4);
        wave(2, 2, 3);

        // Stopped clock while locked.
        repeat (12) cyc(1'b0, 1'b0);
        check("stop_locked", 32'(bus.locked), 32'd0);
        check("stop_fault", 32'(bus.fault), 32'd1);
        wave(2, 2, 16);
        check("restart_not_yet_locked", 32'(bus.locked), 32'd0);
        wave(2, 2, 1);
        check("restart_locked", 32'(bus.locked), 32'd1);
        check("restart_fault_sticky", 32'(bus.fault), 32'd1);

        // Single stretched period, then clear fault and re-lock.
        wave(3, 2, 1);
        wave(2, 2, 2);
        check("stretch_period", 32'(bus.period), 32'd5);
        check("stretch_locked", 32'(bus.locked), 32'd0);
        check("stretch_fault", 32'(bus.fault), 32'd1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("clr_fault", 32'(bus.fault), 32'd0);
        wave(2, 2, 14);
        check("relock_not_yet", 32'(bus.locked), 32'd0);
        wave(2, 2, 1);
        check("relock", 32'(bus.locked), 32'd1);

        // clr_fault coincident with the bad-period re: set wins.
        repeat (3) cyc(1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        check("set_wins_fault", 32'(bus.fault), 32'd1);
        check("set_wins_locked", 32'(bus.locked), 32'd0);

        // Duty distortion with a correct period.
        cyc(1'b0, 1'b1);
        wave(3, 1, 20);
`ifdef CLK_DIV_DUTY_CHECK_EN
        check("duty_locked", 32'(bus.locked), 32'd0);
`else
        check("duty_locked", 32'(bus.locked), 32'd1);
`endif

        // Asynchronous reset mid-cycle while locked.
        wave(2, 2, 20);
        check("pre_rst_locked", 32'(bus.locked), 32'd1);
        #10 rst = 1'b1;
        #1;
        check("arst_locked", 32'(bus.locked), 32'd0);
        check("arst_fault", 32'(bus.fault), 32'd0);
        check("arst_period", 32'(bus.period), 32'd0);
        check("arst_period_valid", 32'(bus.period_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        wave(2, 2, 16);
        check("post_rst_not_yet_locked", 32'(bus.locked), 32'd0);
        wave(2, 2, 1);
        check("post_rst_locked", 32'(bus.locked), 32'd1);

        // Randomized periods, duty, gaps and clears.
        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                hi = 2;
                lo = 2;
            end else if (sel < 8) begin
                hi = $urandom_range(1, 3);
                lo = $urandom_range(1, 3);
            end else begin
                hi = $urandom_range(1, 3);
                lo = $urandom_range(4, 14);
            end
            repeat (hi) cyc(1'b1, rclr());
            repeat (lo) cyc(1'b0, rclr());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
